// File: rtl/nvio2_pkg.sv
// Shared widths and the arbiter FSM state type for the nvio2 register-file slice.
package nvio2_pkg;

    localparam int RF_ADR_W = 13;   // {ctx[6:0], reg[5:0]}
    localparam int RF_DAT_W = 128;
    localparam int CTX_W    = 7;
    localparam int REG_W    = 6;

    typedef enum logic [1:0] {
        IDLE,
        CLR,
        DONE
    } rfarb_state_t;

endpackage

// File: rtl/nvio2_rr_pick.sv
// Round-robin one-hot picker: grants the first set request at or after ptr,
// wrapping around the vector.
module nvio2_rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt
);

    logic          found;
    logic [PW-1:0] idx;

    // Scan from ptr upward with wrap; the first hit wins.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = PW'((int'(ptr) + k) % NREQ);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/nvio2_regfile_arb.sv
// Single-port register-file arbiter: one access per cycle among NREQ
// requesters (starved readers, then writes, then reads), plus a sequencer
// that zeroes registers 1..63 of one context.
module nvio2_regfile_arb
    import nvio2_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int MAXWAIT = 15
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NREQ-1:0]                req_valid,
    input  logic [NREQ-1:0]                req_wr,
    input  logic [NREQ-1:0][RF_ADR_W-1:0]  req_adr,
    input  logic [NREQ-1:0][RF_DAT_W-1:0]  req_dat,
    output logic [NREQ-1:0]                req_ready,
    output logic [NREQ-1:0]                rsp_valid,
    output logic [RF_DAT_W-1:0]            rsp_dat,
    input  logic                           clr_req,
    input  logic [CTX_W-1:0]               clr_ctx,
    output logic                           clr_busy,
    output logic                           clr_done,
    output logic                           rf_wr,
    output logic [RF_ADR_W-1:0]            rf_adr,
    output logic [RF_DAT_W-1:0]            rf_i,
    input  logic [RF_DAT_W-1:0]            rf_o
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int WW = $clog2(MAXWAIT + 1);

    rfarb_state_t         state_q, state_d;
    logic [CTX_W-1:0]     ctx_q, ctx_d;
    logic [REG_W-1:0]     cnt_q, cnt_d;
    logic [PW-1:0]        ptr_q;
    logic [WW-1:0]        wait_cnt_q [NREQ];
    logic                 arb_en;

    logic [NREQ-1:0]      wr_reqs, rd_reqs;
    logic [NREQ-1:0]      wr_gnt, rd_gnt, starve_gnt, gnt;
    logic [PW-1:0]        win_id;
    logic                 win_wr;
    logic                 any_gnt;

    logic                 rd_vld_p1;
    logic [PW-1:0]        rd_id_p1;
    logic [RF_ADR_W-1:0]  adr_hold;
    logic [RF_DAT_W-1:0]  dat_hold;

    assign wr_reqs = req_valid & req_wr;
    assign rd_reqs = req_valid & ~req_wr;

    nvio2_rr_pick #(.NREQ(NREQ), .PW(PW)) u_wr_pick (
        .req (wr_reqs),
        .ptr (ptr_q),
        .gnt (wr_gnt)
    );

    nvio2_rr_pick #(.NREQ(NREQ), .PW(PW)) u_rd_pick (
        .req (rd_reqs),
        .ptr (ptr_q),
        .gnt (rd_gnt)
    );

    // Starved readers: descending scan so the lowest index is left standing.
    always_comb begin
        starve_gnt = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rd_reqs[i] && wait_cnt_q[i] == WW'(MAXWAIT))
                starve_gnt = NREQ'(1) << i;
        end
    end

    // Final grant; forced low while reset is asserted so nothing is granted.
    always_comb begin
        gnt = '0;
        if (arb_en && rst_n) begin
            if (|starve_gnt)
                gnt = starve_gnt;
            else if (|wr_gnt)
                gnt = wr_gnt;
            else
                gnt = rd_gnt;
        end
    end

    // One-hot grant to requester index.
    always_comb begin
        win_id = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i])
                win_id = PW'(i);
        end
    end

    assign any_gnt   = |gnt;
    assign win_wr    = req_wr[win_id];
    assign req_ready = gnt;

    // Clear sequencer next-state and status outputs.
    always_comb begin
        state_d  = state_q;
        ctx_d    = ctx_q;
        cnt_d    = cnt_q;
        arb_en   = 1'b0;
        clr_busy = 1'b0;
        clr_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    ctx_d   = clr_ctx;
                    cnt_d   = REG_W'(1);
                    state_d = CLR;
                end else begin
                    arb_en = 1'b1;
                end
            end
            CLR: begin
                clr_busy = 1'b1;
                cnt_d    = cnt_q + 1'b1;
                if (&cnt_q)
                    state_d = DONE;
            end
            DONE: begin
                clr_busy = 1'b1;
                clr_done = 1'b1;
                arb_en   = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Regfile port: clear writes, else the winner, else hold the address.
    always_comb begin
        rf_wr  = 1'b0;
        rf_adr = adr_hold;
        rf_i   = '0;
        if (state_q == CLR) begin
            rf_wr  = 1'b1;
            rf_adr = {ctx_q, cnt_q};
        end else if (any_gnt) begin
            rf_wr  = win_wr;
            rf_adr = req_adr[win_id];
            if (win_wr)
                rf_i = req_dat[win_id];
        end
    end

    assign rsp_valid = rd_vld_p1 ? (NREQ'(1) << rd_id_p1) : '0;
    assign rsp_dat   = rd_vld_p1 ? rf_o : dat_hold;

    // FSM, round-robin pointer, read-response tag and held port values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ctx_q     <= '0;
            cnt_q     <= '0;
            ptr_q     <= '0;
            rd_vld_p1 <= 1'b0;
            rd_id_p1  <= '0;
            adr_hold  <= '0;
            dat_hold  <= '0;
        end else begin
            state_q   <= state_d;
            ctx_q     <= ctx_d;
            cnt_q     <= cnt_d;
            if (any_gnt)
                ptr_q <= (win_id == PW'(NREQ - 1)) ? '0 : win_id + 1'b1;
            // stage p1: read issued last cycle, data arrives from regfile now
            rd_vld_p1 <= any_gnt & ~win_wr;
            rd_id_p1  <= win_id;
            adr_hold  <= rf_adr;
            dat_hold  <= rsp_dat;
        end
    end

    // Per-reader wait counters: saturate while passed over, clear on grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREQ; i++)
                wait_cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (gnt[i])
                    wait_cnt_q[i] <= '0;
                else if (rd_reqs[i] && wait_cnt_q[i] != WW'(MAXWAIT))
                    wait_cnt_q[i] <= wait_cnt_q[i] + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_nvio2_regfile_arb.sv
// Directed bench for nvio2_regfile_arb with a behavioural single-port regfile.
module tb_nvio2_regfile_arb;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [3:0]          req_valid;
    logic [3:0]          req_wr;
    logic [3:0][12:0]    req_adr;
    logic [3:0][127:0]   req_dat;
    logic [3:0]          req_ready;
    logic [3:0]          rsp_valid;
    logic [127:0]        rsp_dat;
    logic                clr_req;
    logic [6:0]          clr_ctx;
    logic                clr_busy;
    logic                clr_done;
    logic                rf_wr;
    logic [12:0]         rf_adr;
    logic [127:0]        rf_i;
    logic [127:0]        rf_o;

    logic [127:0]        mem [0:8191];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    nvio2_regfile_arb #(.NREQ(4), .MAXWAIT(15)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_wr    (req_wr),
        .req_adr   (req_adr),
        .req_dat   (req_dat),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_dat   (rsp_dat),
        .clr_req   (clr_req),
        .clr_ctx   (clr_ctx),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done),
        .rf_wr     (rf_wr),
        .rf_adr    (rf_adr),
        .rf_i      (rf_i),
        .rf_o      (rf_o)
    );

    // Regfile model: synchronous write, registered read, register 0 reads zero.
    always @(posedge clk) begin
        if (rf_wr)
            mem[rf_adr] <= rf_i;
        rf_o <= (rf_adr[5:0] == 6'd0) ? 128'd0 : mem[rf_adr];
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic clr_all();
        req_valid = '0;
        req_wr    = '0;
        req_adr   = '0;
        req_dat   = '0;
        clr_req   = 1'b0;
        clr_ctx   = '0;
    endtask

    task automatic set_req(input int i, input logic wr, input logic [12:0] adr, input logic [127:0] dat);
        req_valid[i] = 1'b1;
        req_wr[i]    = wr;
        req_adr[i]   = adr;
        req_dat[i]   = dat;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clr_all();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic rd_chk(input string tag, input logic [12:0] adr, input logic [127:0] exp);
        cyc();
        clr_all();
        set_req(0, 1'b0, adr, 128'd0);
        smp();
        chk({tag, "_gnt"}, 128'(req_ready), 128'h1);
        cyc();
        clr_all();
        smp();
        chk({tag, "_vld"}, 128'(rsp_valid), 128'h1);
        chk(tag, rsp_dat, exp);
    endtask

    initial begin
        int done_seen;
        logic [3:0] exp_gnt;

        // Reset values, with a request pending during reset
        clr_all();
        set_req(0, 1'b0, 13'h0085, 128'd0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 128'(req_ready), 128'h0);
        chk("rst_rsp_valid", 128'(rsp_valid), 128'h0);
        chk("rst_rsp_dat",   rsp_dat,         128'h0);
        chk("rst_clr_busy",  128'(clr_busy),  128'h0);
        chk("rst_clr_done",  128'(clr_done),  128'h0);
        chk("rst_rf_wr",     128'(rf_wr),     128'h0);
        chk("rst_rf_adr",    128'(rf_adr),    128'h0);
        chk("rst_rf_i",      rf_i,            128'h0);
        clr_all();
        rst_n = 1'b1;

        // Preload 0x0085 = A5 via requester 0
        cyc();
        set_req(0, 1'b1, 13'h0085, 128'hA5);
        smp();
        chk("pre_ready", 128'(req_ready), 128'h1);
        chk("pre_rf_wr", 128'(rf_wr),     128'h1);
        chk("pre_rf_adr", 128'(rf_adr),   128'h0085);
        chk("pre_rf_i",  rf_i,            128'hA5);

        // Single read
        cyc();
        clr_all();
        set_req(0, 1'b0, 13'h0085, 128'd0);
        smp();
        chk("rd1_ready",  128'(req_ready), 128'h1);
        chk("rd1_rf_wr",  128'(rf_wr),     128'h0);
        chk("rd1_rf_adr", 128'(rf_adr),    128'h0085);
        cyc();
        clr_all();
        smp();
        chk("rd1_rsp_valid", 128'(rsp_valid), 128'h1);
        chk("rd1_rsp_dat",   rsp_dat,         128'hA5);
        chk("idle_rf_wr",    128'(rf_wr),     128'h0);
        chk("idle_adr_hold", 128'(rf_adr),    128'h0085);

        // Write by req1 then back-to-back read by req2
        cyc();
        set_req(1, 1'b1, 13'h0042, 128'h1234);
        smp();
        chk("wr_ready", 128'(req_ready), 128'h2);
        chk("wr_rf_i",  rf_i,            128'h1234);
        cyc();
        clr_all();
        set_req(2, 1'b0, 13'h0042, 128'd0);
        smp();
        chk("raw_ready", 128'(req_ready), 128'h4);
        cyc();
        clr_all();
        smp();
        chk("raw_rsp_valid", 128'(rsp_valid), 128'h4);
        chk("raw_rsp_dat",   rsp_dat,         128'h1234);
        cyc();
        smp();
        chk("hold_rsp_valid", 128'(rsp_valid), 128'h0);
        chk("hold_rsp_dat",   rsp_dat,         128'h1234);

        // Round-robin among four continuous readers
        do_reset();
        for (int k = 0; k < 8; k++) begin
            cyc();
            for (int i = 0; i < 4; i++)
                set_req(i, 1'b0, 13'h0085, 128'd0);
            smp();
            exp_gnt = 4'b0001 << (k % 4);
            chk($sformatf("rr_gnt%0d", k), 128'(req_ready), 128'(exp_gnt));
            if (k > 0) begin
                exp_gnt = 4'b0001 << ((k - 1) % 4);
                chk($sformatf("rr_rsp%0d", k), 128'(rsp_valid), 128'(exp_gnt));
                chk($sformatf("rr_dat%0d", k), rsp_dat, 128'hA5);
            end
        end
        cyc();
        clr_all();
        smp();
        chk("rr_rsp_last", 128'(rsp_valid), 128'h8);

        // Starvation: req0 reads while req1..3 write continuously
        do_reset();
        for (int k = 0; k < 16; k++) begin
            cyc();
            set_req(0, 1'b0, 13'h0085, 128'd0);
            for (int i = 1; i < 4; i++)
                set_req(i, 1'b1, 13'(13'h0200 + i), 128'(128'h7700 + i));
            smp();
            exp_gnt = (k < 15) ? (4'b0001 << (1 + (k % 3))) : 4'b0001;
            chk($sformatf("stv_gnt%0d", k), 128'(req_ready), 128'(exp_gnt));
        end
        cyc();
        clr_all();
        smp();
        chk("stv_rsp_valid", 128'(rsp_valid), 128'h1);
        chk("stv_rsp_dat",   rsp_dat,         128'hA5);
        rd_chk("stv_wr3", 13'h0203, 128'h7703);

        // Context clear of ctx 5 with req0 pending
        do_reset();
        for (int r = 1; r < 64; r++) begin
            cyc();
            clr_all();
            set_req(0, 1'b1, 13'(13'h0140 + r), 128'(128'h5000 + r));
        end
        cyc();
        clr_all();
        set_req(0, 1'b1, 13'h010A, 128'h4444);
        cyc();
        clr_all();
        set_req(0, 1'b1, 13'h018A, 128'h6666);
        rd_chk("pre_c5r10", 13'h014A, 128'h500A);

        cyc();
        clr_all();
        set_req(0, 1'b0, 13'h0085, 128'd0);
        clr_req = 1'b1;
        clr_ctx = 7'd5;
        smp();
        chk("clr0_status", 128'({req_ready, rf_wr, clr_busy, clr_done}), 128'h0);
        for (int k = 1; k < 64; k++) begin
            cyc();
            clr_req = 1'b0;
            smp();
            chk($sformatf("clr_w%0d", k),
                128'({rf_wr, rf_adr, req_ready, clr_busy, clr_done}),
                128'({1'b1, 13'(13'h0140 + k), 4'b0000, 1'b1, 1'b0}));
            chk($sformatf("clr_i%0d", k), rf_i, 128'h0);
        end
        cyc();
        smp();
        chk("done_pulse", 128'(clr_done),  128'h1);
        chk("done_busy",  128'(clr_busy),  128'h1);
        chk("done_ready", 128'(req_ready), 128'h1);
        chk("done_adr",   128'(rf_adr),    128'h0085);
        cyc();
        clr_all();
        smp();
        chk("post_done",  128'(clr_done),  128'h0);
        chk("post_busy",  128'(clr_busy),  128'h0);
        chk("post_rsp",   128'(rsp_valid), 128'h1);
        chk("post_dat",   rsp_dat,         128'hA5);
        rd_chk("c5r1",  13'h0141, 128'h0);
        rd_chk("c5r32", 13'h0160, 128'h0);
        rd_chk("c5r63", 13'h017F, 128'h0);
        rd_chk("c4r10", 13'h010A, 128'h4444);
        rd_chk("c6r10", 13'h018A, 128'h6666);

        // Async reset in the middle of a clear of ctx 3
        cyc();
        clr_all();
        set_req(0, 1'b0, 13'h0085, 128'd0);
        clr_req = 1'b1;
        clr_ctx = 7'd3;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            clr_req = 1'b0;
        end
        smp();
        chk("mid_w20_adr", 128'(rf_adr), 128'h00D4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rf_wr",   128'(rf_wr),     128'h0);
        chk("mid_rst_rf_adr",  128'(rf_adr),    128'h0);
        chk("mid_rst_busy",    128'(clr_busy),  128'h0);
        chk("mid_rst_ready",   128'(req_ready), 128'h0);
        chk("mid_rst_rsp",     128'(rsp_valid), 128'h0);
        chk("mid_rst_rsp_dat", rsp_dat,         128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        smp();
        chk("after_rst_ready", 128'(req_ready), 128'h1);
        chk("after_rst_busy",  128'(clr_busy),  128'h0);
        done_seen = 0;
        for (int k = 0; k < 70; k++) begin
            cyc();
            smp();
            if (clr_done || clr_busy)
                done_seen++;
        end
        chk("no_done_after_abort", 128'(done_seen), 128'h0);
        cyc();
        clr_all();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/nvio2_regfile_arb.md
Name: nvio2_regfile_arb

Overview:
Arbitrates the single-port 8192x128 register file (128 contexts x 64 registers, adr = {ctx[6:0], reg[5:0]}) between NREQ requesters issuing reads and writes. It also contains a context-clear sequencer that zeroes registers 1..63 of one context. Each cycle it grants at most one access and returns read data tagged to the winning requester. It sits between the issue/writeback logic and nvio2_regfile.

Parameters:
NREQ, 4, number of requesters (2..8)
MAXWAIT, 15, cycles a pending read may be passed over by writes before it is forced ahead

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  request pending, one bit per requester
req_wr  in  NREQ  1 = write, 0 = read
req_adr  in  NREQx13  address per requester
req_dat  in  NREQx128  write data per requester
req_ready  out  NREQ  one-hot grant; transfer when valid&ready
rsp_valid  out  NREQ  one-hot read-data-valid
rsp_dat  out  128  read data
clr_req  in  1  start context clear (level, sampled in IDLE)
clr_ctx  in  7  context to clear
clr_busy  out  1  clear in progress
clr_done  out  1  one-cycle pulse after the last clear write
rf_wr  out  1  to regfile wr
rf_adr  out  13  to regfile adr
rf_i  out  128  to regfile i
rf_o  in  128  from regfile o; valid the cycle after rf_adr is presented

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_dat=0, clr_busy=0, clr_done=0, rf_wr=0, rf_adr=0, rf_i=0. FSM=IDLE, rr pointer=0, wait counters=0.
- Reset asserted mid-operation aborts any clear immediately. No rsp_valid is produced for a read granted in the cycle reset asserts.
- FSM states: IDLE, CLR, DONE.
  - IDLE: if clr_req=1, latch clr_ctx, set reg counter=1, go to CLR. Clear takes priority over requesters that same cycle.
  - CLR: rf_wr=1, rf_adr={ctx,cnt}, rf_i=0, req_ready=0. cnt increments each cycle. At cnt=63, go to DONE. A clear therefore takes exactly 63 cycles of writes.
  - DONE: clr_done=1 for one cycle, normal arbitration resumes in the same cycle, then back to IDLE.
  - clr_busy=1 in CLR and DONE.
- Arbitration (IDLE/DONE) is combinational on req_* and drives rf_* in the same cycle:
  - Priority 1: a starved reader (wait counter == MAXWAIT), lowest index first.
  - Priority 2: writes, round-robin among write requesters.
  - Priority 3: reads, round-robin among read requesters.
- The single round-robin pointer advances to winner+1 mod NREQ after any grant.
- A reader's wait counter increments each cycle it is valid and not granted, saturating at MAXWAIT. It resets to 0 on grant.
- Read latency: grant in cycle T, rf_adr driven in T. In T+1, rsp_valid[id]=1 and rsp_dat=rf_o (combinational pass-through; rsp_dat holds its last value otherwise). Requester id is registered at T.
- Register 0 of every context reads 0; this comes from the regfile, and the arbiter does not special-case it.
- Writes complete at the clock edge ending cycle T. A read granted at T+1 to the same address returns the new data.
- No grant cycles: rf_wr=0, rf_adr holds its previous value.
- At most one req_ready bit is set per cycle. req_ready never asserts for a non-valid requester.

Decomposition:
- nvio2_pkg gets: RF_ADR_W=13, RF_DAT_W=128, CTX_W=7, REG_W=6, and the typedef enum {IDLE,CLR,DONE} rfarb_state_t.
- One sub-module, nvio2_rr_pick: NREQ-wide round-robin one-hot picker (request vector plus pointer in, grant out). Instantiated twice, once for writes and once for reads.

Test Plan:
- Single read: req0 read adr 13'h0085 with mem preloaded to 128'hA5 -> req_ready[0] in T, rsp_valid[0] and rsp_dat=128'hA5 in T+1.
- Write then read: req1 writes 13'h0042=128'h1234 in cycle 0; req2 reads 13'h0042 in cycle 1 -> rsp_valid[2] with 128'h1234 in cycle 2.
- Round-robin fairness: all 4 requesters reading continuously for 8 cycles -> grants go 0,1,2,3,0,1,2,3.
- Starvation: req0 reads while req1..3 write continuously -> req0 is granted exactly after MAXWAIT=15 passed-over cycles.
- Context clear: preload ctx 5 regs 1..63 with nonzero data, pulse clr_req with clr_ctx=5 while req0 is valid -> 63 writes at adr 0x141..0x17F, req_ready=0 throughout, clr_done in cycle 64. Subsequent reads of those registers return 0; ctx 4 and ctx 6 are unchanged.
- Async reset mid-clear: deassert rst_n at clear write 20 -> all outputs go to reset values immediately, FSM=IDLE after release, no clr_done pulse.
